// File: rtl/cpu_types_pkg.sv
`default_nettype none
// ============================================================================
// cpu_types_pkg : shared pipeline types, stage payload structs, occupancy helper
// Revision      : 1.0
// ============================================================================
package cpu_types_pkg;

  typedef logic [1:0] pipe_cnt_t;

  localparam int PIPE_DEPTH = 2;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc_next;
  } ifid_t;

  typedef struct packed {
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [5:0]  op;
  } idex_t;

  function automatic pipe_cnt_t occupancy(input logic main_v, input logic skid_v);
    return pipe_cnt_t'({1'b0, main_v} + {1'b0, skid_v});
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_stage_buf.sv
`default_nettype none
// ============================================================================
// pipe_stage_buf : valid/ready pipeline register with one-entry skid and flush
// Revision       : 1.0
// ============================================================================
module pipe_stage_buf
  import cpu_types_pkg::*;
#(
  parameter int                DATA_W = 64,
  parameter logic [DATA_W-1:0] BUBBLE = '0
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output pipe_cnt_t         count
);

  logic              r_main_v;
  logic              r_skid_v;
  logic [DATA_W-1:0] r_main_d;
  logic [DATA_W-1:0] r_skid_d;
  logic              w_push;
  logic              w_pop;

  // in_ready depends only on the skid flop, so no input reaches it combinationally
  assign in_ready  = ~r_skid_v;
  assign w_push    = in_valid & ~r_skid_v;
  assign w_pop     = r_main_v & out_ready;
  assign out_valid = r_main_v;
  assign out_data  = r_main_d;
  assign count     = occupancy(r_main_v, r_skid_v);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_main_v <= 1'b0;
      r_skid_v <= 1'b0;
      r_main_d <= BUBBLE;
      r_skid_d <= BUBBLE;
    end else if (flush) begin
      r_main_v <= 1'b0;
      r_skid_v <= 1'b0;
      r_main_d <= BUBBLE;
      r_skid_d <= BUBBLE;
    end else if (r_skid_v) begin
      if (w_pop) begin
        r_main_d <= r_skid_d;
        r_skid_d <= BUBBLE;
        r_skid_v <= 1'b0;
      end
    end else if (r_main_v) begin
      if (w_push && w_pop) begin
        r_main_d <= in_data;
      end else if (w_push) begin
        r_skid_d <= in_data;
        r_skid_v <= 1'b1;
      end else if (w_pop) begin
        r_main_v <= 1'b0;
        r_main_d <= BUBBLE;
      end
    end else if (w_push) begin
      r_main_d <= in_data;
      r_main_v <= 1'b1;
    end
  end

endmodule
`default_nettype wire
